// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared constants, read-source enum and byte picker for mem_io_responder
package mem_io_pkg;

    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CNT_ADDR  = 18'h30004;

    typedef enum logic [1:0] {
        SRC_RAM = 2'd0,
        SRC_RX  = 2'd1,
        SRC_CNT = 2'd2,
        SRC_ERR = 2'd3
    } rd_src_e;

    // Little-endian byte k of a 32-bit word
    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - byte circular FIFO with extended pointers, count, full and almost-full flags
module tx_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int MARGIN = 2,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    input  logic [7:0]    push_data,
    output logic [7:0]    tdata,
    output logic          tvalid,
    input  logic          tready,
    output logic [PW:0]   count,
    output logic          full,
    output logic          almost_full
);

    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [7:0]  buf_q [DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit distinguishes full from empty, so count is a plain subtraction
    assign count       = wr_ptr_q - rd_ptr_q;
    assign full        = (count == (PW+1)'(DEPTH));
    assign almost_full = (count >= (PW+1)'(DEPTH - MARGIN));
    assign tvalid      = (count != '0);
    assign tdata       = buf_q[rd_ptr_q[PW-1:0]];
    assign do_pop      = tvalid && tready;
    // A pop frees the head slot this same edge, so a push at full is still accepted
    assign do_push     = push_valid && (!full || do_pop);

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage, not reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            buf_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU byte-bus responder: RAM, UART TX FIFO/RX pop, cycle counter, stop; option MEM_IO_BOUNDS_CHECK_EN
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_AW     = 17,
    parameter int TXF_DEPTH  = 16,
    parameter int TXF_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_done
`ifdef MEM_IO_BOUNDS_CHECK_EN
    ,
    output logic        addr_err
`endif
);

    localparam int TXF_PW = $clog2(TXF_DEPTH);

    logic [7:0]        ram [2**RAM_AW];
    logic [7:0]        ram_rdata_q;
    logic [RAM_AW-1:0] ram_addr;

    logic io_sel, uart_sel, cnt_sel, err_sel;
    logic ram_we, uart_rd, uart_wr, cnt_rd, stop_wr;
    logic txf_push;
    logic [7:0] txf_push_data;
    logic [TXF_PW:0] txf_count;
    logic txf_full;

    logic        rd_valid_q, rd_valid_d;
    rd_src_e     src_q, src_d;
    logic [1:0]  byte_sel_q, byte_sel_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic        stop_pend_q, stop_pend_d;
    logic        done_q, done_d;
`ifdef MEM_IO_BOUNDS_CHECK_EN
    logic        addr_err_q, addr_err_d;
`endif

    // Address decode; only mem_a[17:0] matters
    assign io_sel   = (mem_a[17:16] == IO_UART_ADDR[17:16]);
    assign uart_sel = io_sel && (mem_a[2] == IO_UART_ADDR[2]);
    assign cnt_sel  = io_sel && (mem_a[2] == IO_CNT_ADDR[2]);
`ifdef MEM_IO_BOUNDS_CHECK_EN
    assign err_sel  = (mem_a[17:16] == 2'b10);
`else
    assign err_sel  = 1'b0;
`endif
    assign ram_addr = mem_a[RAM_AW-1:0];
    assign ram_we   = mem_wr && !io_sel && !err_sel;
    assign uart_rd  = uart_sel && !mem_wr;
    assign uart_wr  = uart_sel && mem_wr;
    assign cnt_rd   = cnt_sel && !mem_wr;
    assign stop_wr  = cnt_sel && mem_wr;

    // RX byte is consumed in the same cycle as the read address
    assign rx_pop = uart_rd && rx_valid && !rst_in;

    // Zero bytes on the UART port are dropped; the stop marker 0x00 goes in regardless
    assign txf_push      = (uart_wr && (mem_dout != 8'h00)) || stop_wr;
    assign txf_push_data = stop_wr ? 8'h00 : mem_dout;

    tx_fifo #(
        .DEPTH  (TXF_DEPTH),
        .MARGIN (TXF_MARGIN)
    ) u_tx_fifo (
        .clk         (clk_in),
        .rst         (rst_in),
        .push_valid  (txf_push),
        .push_data   (txf_push_data),
        .tdata       (tx_data),
        .tvalid      (tx_valid),
        .tready      (tx_ready),
        .count       (txf_count),
        .full        (txf_full),
        .almost_full (io_buffer_full)
    );

    // Synchronous byte RAM, read-before-write within one edge
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_addr] <= mem_dout;
        end
        ram_rdata_q <= ram[ram_addr];
    end

    // Next-state for read pipeline, counter, snapshot and stop tracking
    always_comb begin
        rd_valid_d  = !mem_wr;
        byte_sel_d  = mem_a[1:0];
        src_d       = SRC_RAM;
        rx_byte_d   = rx_byte_q;
        cnt_d       = cnt_q + 32'd1;
        snap_d      = snap_q;
        stop_pend_d = stop_pend_q || stop_wr;
        done_d      = done_q || (stop_pend_q && !tx_valid);
        if (err_sel) begin
            src_d = SRC_ERR;
        end else if (uart_sel) begin
            src_d = SRC_RX;
        end else if (cnt_sel) begin
            src_d = SRC_CNT;
        end
        if (uart_rd) begin
            rx_byte_d = rx_valid ? rx_data : 8'h00;
        end
        if (cnt_rd && (mem_a[1:0] == 2'b00)) begin
            snap_d = cnt_q;
        end
    end

`ifdef MEM_IO_BOUNDS_CHECK_EN
    // Sticky flag for any touch of the unmapped window
    always_comb begin
        addr_err_d = addr_err_q || err_sel;
    end
    assign addr_err = addr_err_q;
`endif

    // State registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_valid_q  <= 1'b0;
            src_q       <= SRC_RAM;
            byte_sel_q  <= 2'b00;
            rx_byte_q   <= 8'h00;
            cnt_q       <= 32'h0;
            snap_q      <= 32'h0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef MEM_IO_BOUNDS_CHECK_EN
            addr_err_q  <= 1'b0;
`endif
        end else begin
            rd_valid_q  <= rd_valid_d;
            src_q       <= src_d;
            byte_sel_q  <= byte_sel_d;
            rx_byte_q   <= rx_byte_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
`ifdef MEM_IO_BOUNDS_CHECK_EN
            addr_err_q  <= addr_err_d;
`endif
        end
    end

    // Read-data mux from registered source; idle or post-reset cycles read as zero
    always_comb begin
        mem_din = 8'h00;
        if (rd_valid_q) begin
            case (src_q)
                SRC_RAM: mem_din = ram_rdata_q;
                SRC_RX:  mem_din = rx_byte_q;
                SRC_CNT: mem_din = pick_byte(snap_q, byte_sel_q);
                default: mem_din = 8'hFF;
            endcase
        end
    end

    assign program_done = done_q;

    logic unused_sigs;
    assign unused_sigs = ^{mem_a[31:18], txf_full, txf_count};

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed self-checking bench for mem_io_responder
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a = 32'h0;
    logic [7:0]  mem_dout = 8'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        program_done;
`ifdef MEM_IO_BOUNDS_CHECK_EN
    logic        addr_err;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] tb_cyc;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .program_done   (program_done)
`ifdef MEM_IO_BOUNDS_CHECK_EN
        ,
        .addr_err       (addr_err)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle count since reset release
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) tb_cyc <= 32'h0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one bus cycle, then move to the next negedge
    task automatic drive(input logic [31:0] a, input logic w, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = w;
        mem_dout = d;
        @(negedge clk_in);
    endtask

    task automatic set_idle();
        mem_a    = 32'h0;
        mem_wr   = 1'b0;
        mem_dout = 8'h0;
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        check("rst_mem_din", {24'h0, mem_din}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_io_full", {31'h0, io_buffer_full}, 32'h0);
        check("rst_done", {31'h0, program_done}, 32'h0);
        check("rst_rx_pop", {31'h0, rx_pop}, 32'h0);
`ifdef MEM_IO_BOUNDS_CHECK_EN
        check("rst_addr_err", {31'h0, addr_err}, 32'h0);
`endif
        rst_in = 1'b0;

        // RAM round trip
        drive(32'h00010, 1'b1, 8'hA5);
        mem_a  = 32'h00010;
        mem_wr = 1'b0;
        check("ram_after_wr", {24'h0, mem_din}, 32'h0);
        @(negedge clk_in);
        check("ram_rt", {24'h0, mem_din}, 32'h000000A5);
        drive(32'h1FFFF, 1'b1, 8'h3C);
        drive(32'h1FFFF, 1'b0, 8'h00);
        check("ram_top", {24'h0, mem_din}, 32'h0000003C);
        drive(32'h00010, 1'b0, 8'h00);
        check("ram_keep", {24'h0, mem_din}, 32'h000000A5);

`ifdef MEM_IO_BOUNDS_CHECK_EN
        drive(32'h00040, 1'b1, 8'h11);
        drive(32'h20040, 1'b1, 8'h77);
        drive(32'h20040, 1'b0, 8'h00);
        check("err_rd", {24'h0, mem_din}, 32'h000000FF);
        drive(32'h00040, 1'b0, 8'h00);
        check("err_wr_dropped", {24'h0, mem_din}, 32'h00000011);
        check("addr_err", {31'h0, addr_err}, 32'h1);
`else
        drive(32'h20040, 1'b1, 8'h77);
        drive(32'h00040, 1'b0, 8'h00);
        check("alias_rd", {24'h0, mem_din}, 32'h00000077);
`endif

        // UART output: zero byte is skipped
        tx_ready = 1'b1;
        drive(32'h30000, 1'b1, 8'h41);
        check("tx_41_valid", {31'h0, tx_valid}, 32'h1);
        check("tx_41", {24'h0, tx_data}, 32'h00000041);
        drive(32'h30000, 1'b1, 8'h00);
        check("tx_zero_skip", {31'h0, tx_valid}, 32'h0);
        drive(32'h30000, 1'b1, 8'h42);
        check("tx_42", {24'h0, tx_data}, 32'h00000042);
        check("tx_42_valid", {31'h0, tx_valid}, 32'h1);
        set_idle();
        @(negedge clk_in);
        check("tx_drained", {31'h0, tx_valid}, 32'h0);

        // Fill: almost-full at 14, full drop, push+pop at full
        tx_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            drive(32'h30000, 1'b1, 8'(i));
            if (i == 13) check("io_full_at13", {31'h0, io_buffer_full}, 32'h0);
        end
        check("io_full_at14", {31'h0, io_buffer_full}, 32'h1);
        drive(32'h30000, 1'b1, 8'd15);
        drive(32'h30000, 1'b1, 8'd16);
        drive(32'h30000, 1'b1, 8'd17);
        set_idle();
        tx_ready = 1'b1;
        check("full_head", {24'h0, tx_data}, 32'h1);
        drive(32'h30000, 1'b1, 8'h99);
        set_idle();
        for (int i = 2; i <= 16; i++) begin
            check($sformatf("drain_%0d", i), {24'h0, tx_data}, 32'(i));
            @(negedge clk_in);
        end
        check("drain_pushpop", {24'h0, tx_data}, 32'h00000099);
        check("drain_pushpop_v", {31'h0, tx_valid}, 32'h1);
        @(negedge clk_in);
        check("drain_empty", {31'h0, tx_valid}, 32'h0);
        check("drain_io_full", {31'h0, io_buffer_full}, 32'h0);

        // UART input
        rx_valid = 1'b1;
        rx_data  = 8'h37;
        mem_a    = 32'h30000;
        mem_wr   = 1'b0;
        #1;
        check("rx_pop_on", {31'h0, rx_pop}, 32'h1);
        @(negedge clk_in);
        set_idle();
        #1;
        check("rx_pop_ram_rd", {31'h0, rx_pop}, 32'h0);
        check("rx_data_rd", {24'h0, mem_din}, 32'h00000037);
        rx_valid = 1'b0;
        rx_data  = 8'h99;
        mem_a    = 32'h30000;
        #1;
        check("rx_pop_novalid", {31'h0, rx_pop}, 32'h0);
        @(negedge clk_in);
        set_idle();
        check("rx_empty_rd", {24'h0, mem_din}, 32'h0);

        // Reset between read address and data
        drive(32'h00020, 1'b1, 8'h5A);
        mem_a  = 32'h00020;
        mem_wr = 1'b0;
        @(posedge clk_in);
        #2;
        check("pre_rst_rd", {24'h0, mem_din}, 32'h0000005A);
        rst_in = 1'b1;
        #1;
        check("rst_async_din", {24'h0, mem_din}, 32'h0);
        mem_a    = 32'h00030;
        mem_wr   = 1'b1;
        mem_dout = 8'h00;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("rst_release_din", {24'h0, mem_din}, 32'h0);
        @(negedge clk_in);
        check("rst_no_stale", {24'h0, mem_din}, 32'h0);
        set_idle();

        // Counter snapshot at 0x100, then at 0x1FF (byte 1 must stay from snapshot)
        for (int g = 0; g < 1000 && tb_cyc != 32'h100; g++) @(negedge clk_in);
        check("cnt_wait_100", tb_cyc, 32'h100);
        drive(32'h30004, 1'b0, 8'h00);
        check("cnt100_b0", {24'h0, mem_din}, 32'h00);
        drive(32'h30005, 1'b0, 8'h00);
        check("cnt100_b1", {24'h0, mem_din}, 32'h01);
        drive(32'h30006, 1'b0, 8'h00);
        check("cnt100_b2", {24'h0, mem_din}, 32'h00);
        drive(32'h30007, 1'b0, 8'h00);
        check("cnt100_b3", {24'h0, mem_din}, 32'h00);
        set_idle();
        for (int g = 0; g < 1000 && tb_cyc != 32'h1FF; g++) @(negedge clk_in);
        check("cnt_wait_1ff", tb_cyc, 32'h1FF);
        drive(32'h30004, 1'b0, 8'h00);
        check("cnt1ff_b0", {24'h0, mem_din}, 32'hFF);
        drive(32'h30005, 1'b0, 8'h00);
        check("cnt1ff_b1", {24'h0, mem_din}, 32'h01);
        drive(32'h30006, 1'b0, 8'h00);
        check("cnt1ff_b2", {24'h0, mem_din}, 32'h00);
        set_idle();

        // Stop sequence
        tx_ready = 1'b0;
        drive(32'h30000, 1'b1, 8'h11);
        drive(32'h30000, 1'b1, 8'h22);
        drive(32'h30000, 1'b1, 8'h33);
        drive(32'h30004, 1'b1, 8'h99);
        set_idle();
        check("stop_not_done", {31'h0, program_done}, 32'h0);
        tx_ready = 1'b1;
        check("stop_b0", {24'h0, tx_data}, 32'h11);
        @(negedge clk_in);
        check("stop_b1", {24'h0, tx_data}, 32'h22);
        @(negedge clk_in);
        check("stop_b2", {24'h0, tx_data}, 32'h33);
        @(negedge clk_in);
        check("stop_marker", {24'h0, tx_data}, 32'h00);
        check("stop_marker_v", {31'h0, tx_valid}, 32'h1);
        check("stop_done_early", {31'h0, program_done}, 32'h0);
        @(negedge clk_in);
        check("stop_empty", {31'h0, tx_valid}, 32'h0);
        check("stop_done_lag", {31'h0, program_done}, 32'h0);
        @(negedge clk_in);
        check("stop_done", {31'h0, program_done}, 32'h1);
        repeat (3) @(negedge clk_in);
        check("stop_done_hold", {31'h0, program_done}, 32'h1);
        drive(32'h30000, 1'b1, 8'h55);
        check("post_stop_tx", {24'h0, tx_data}, 32'h55);
        check("post_stop_done", {31'h0, program_done}, 32'h1);
        set_idle();
        @(negedge clk_in);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus.
- Services `mem_a`, `mem_dout` and `mem_wr` issued by the core and returns read data on `mem_din` exactly one cycle later.
- Contains 128 KB of byte RAM, a UART TX FIFO, an RX byte pop port, a free-running cycle counter and program-stop detection, per the memory map at 0x30000/0x30004.
- Sits between the CPU top and the board UART/host link.

Parameters:
- RAM_AW, 17, byte-address width of RAM (2^17 = 128 KB).
- TXF_DEPTH, 16, TX FIFO entries; power of 2, minimum 4.
- TXF_MARGIN, 2, free entries still left when `io_buffer_full` asserts; covers CPU writes already in flight.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- mem_a  in  32  byte address from the CPU; only [17:0] is decoded.
- mem_dout  in  8  write data from the CPU.
- mem_wr  in  1  1 = write, 0 = read.
- mem_din  out  8  read data, valid the cycle after the address.
- io_buffer_full  out  1  TX FIFO almost-full, fed to the CPU.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  rx_data holds a byte.
- rx_pop  out  1  one-cycle pulse that consumes rx_data.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte this cycle.
- program_done  out  1  sticky; program stopped and TX FIFO drained.

Behaviour:
- Decode:
  - `io_sel = mem_a[17:16]==2'b11`.
  - Otherwise RAM at `mem_a[RAM_AW-1:0]`.
  - io_sel with `mem_a[2]==0` is the UART port (0x30000).
  - io_sel with `mem_a[2]==1` is the counter/stop port (0x30004..0x30007).
- RAM:
  - Synchronous byte RAM, no reset of contents.
  - Write commits at the posedge where `mem_wr=1`.
  - A read at cycle N drives `mem_din` at N+1.
  - Read-after-write to the same address on the next cycle returns the new data.
- Read-data mux: source select and `mem_a[1:0]` are registered at cycle N; `mem_din` is selected from them at N+1. Sources:
  - RAM output.
  - RX byte latched at N.
  - Counter snapshot byte.
- UART read (0x30000, `mem_wr=0`):
  - If rx_valid: `rx_pop=1` for that cycle, and rx_data is returned at N+1.
  - Otherwise return 0x00 and leave `rx_pop=0`.
- UART write (0x30000, `mem_wr=1`):
  - Push `mem_dout` into the TX FIFO.
  - 0x00 is ignored (no push).
  - A push while the FIFO is full is dropped; the CPU is responsible via `io_buffer_full`.
- TX FIFO:
  - Circular buffer with a pointer width of log2(TXF_DEPTH)+1.
  - `tx_valid = !empty`, `tx_data` = head entry.
  - Pops on `tx_valid && tx_ready`.
  - Simultaneous push and pop is legal at any fill level, including full.
  - `io_buffer_full = count >= TXF_DEPTH-TXF_MARGIN`.
- Cycle counter:
  - 32 bits, cleared by reset, increments every clock, wraps 0xFFFFFFFF -> 0.
  - A read of 0x30004 snapshots the counter into a 32-bit register.
  - A read of 0x30004+k returns snapshot byte k (little-endian).
  - Bytes 1..3 come from the snapshot, so a 4-byte load is coherent.
- Stop (write to 0x30004):
  - Push 0x00 into the TX FIFO; this bypasses the ignore rule.
  - Set `stop_pend`.
  - `program_done` sets when `stop_pend` is set and the FIFO is empty; it holds until reset.
  - Further UART writes after `stop_pend` are still accepted.
- Reset (async, any time): outputs and state go to
  - mem_din=0, rx_pop=0, tx_valid=0, io_buffer_full=0, program_done=0;
  - FIFO pointers, counter, snapshot and stop_pend cleared;
  - in-flight read discarded.

Optional Feature:
- `MEM_IO_BOUNDS_CHECK_EN`, with a port `addr_err` (out, 1).
- When defined:
  - Any access to 0x20000..0x2FFFF, i.e. `mem_a[17:16]==2'b10`, sets sticky `addr_err`.
  - Such reads return 0xFF.
  - Such writes are discarded.
- When undefined:
  - The port is absent.
  - These addresses alias into RAM modulo 2^RAM_AW (only the [16:0] bits are used).

Decomposition:
- Shared package `mem_io_pkg` holds:
  - constants IO_UART_ADDR=18'h30000 and IO_CNT_ADDR=18'h30004;
  - a read-source enum {SRC_RAM, SRC_RX, SRC_CNT, SRC_ERR}.
- One natural sub-module: `tx_fifo`, parameterised by depth and margin, exposing count, full and almost_full.
- RAM inferred inline.

Test Plan:
- RAM round trip: write 0xA5 @0x00010, then read @0x00010 the next cycle -> `mem_din`=0xA5 exactly one cycle after the read.
- UART output:
  - Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence 0x41, 0x42 only.
  - Hold tx_ready=0 for 14 pushes -> io_buffer_full rises at count 14 (depth 16, margin 2).
- UART input:
  - rx_valid=1, rx_data=0x37, read 0x30000 -> rx_pop pulses one cycle, mem_din=0x37.
  - With rx_valid=0 -> mem_din=0x00, no pop.
- Counter: read 0x30004..0x30007 on consecutive cycles, with the counter preloaded by running 0x100 cycles from reset -> bytes {0x00 or 0x01 as appropriate, 0x01, 0x00, 0x00}, coherent with the snapshot taken on the 0x30004 read.
- Stop: three tx bytes queued, then write 0x30004 -> 0x00 emitted last; program_done rises the cycle after the FIFO goes empty and stays high.
- Reset mid-read: assert rst_in asynchronously between a RAM read address and its data cycle -> mem_din=0 immediately; no stale byte after deassert.
